// File: rtl/fact_pkg.sv
// Shared types and constants for the iterative factorial engine.
package fact_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned ACC_INIT   = 1;
  localparam int unsigned CMP_THRESH = 1;

endpackage

// File: rtl/fact_down_cnt.sv
// Loadable down-counter holding the next factorial multiplicand.
module fact_down_cnt #(
  parameter int unsigned SIZE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_en,
  input  logic [SIZE-1:0] i_d,
  output logic [SIZE-1:0] o_q
);

  logic [SIZE-1:0] r_q;

  // Load has priority over decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end else if (i_en) begin
      r_q <= r_q - SIZE'(1);
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fact_iter_unit.sv
// Iterative unsigned factorial: result = n! mod 2^SIZE, one multiply per cycle.
module fact_iter_unit
  import fact_pkg::*;
#(
  parameter int unsigned SIZE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE-1:0] n,
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] result,
  output logic            overflow
);

  localparam int unsigned PW = 2 * SIZE;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [SIZE-1:0] r_acc;
  logic [SIZE-1:0] w_acc_nxt;
  logic            r_ovf_run;
  logic            w_ovf_run_nxt;
  logic [SIZE-1:0] r_result;
  logic [SIZE-1:0] w_result_nxt;
  logic            r_overflow;
  logic            w_overflow_nxt;
  logic            r_busy;
  logic            w_busy_nxt;
  logic            r_done;
  logic            w_done_nxt;

  logic            w_load;
  logic            w_dec;
  logic [SIZE-1:0] w_cnt;
  logic            w_gt;
  logic [PW-1:0]   w_prod;
  logic            w_prod_ovf;

  fact_down_cnt #(.SIZE(SIZE)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_en   (w_dec),
    .i_d    (n),
    .o_q    (w_cnt)
  );

  // Full-width product so overflow sees the bits dropped by truncation.
  assign w_gt       = (w_cnt > SIZE'(CMP_THRESH));
  assign w_prod     = PW'(r_acc) * PW'(w_cnt);
  assign w_prod_ovf = |w_prod[PW-1:SIZE];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_ovf_run  <= 1'b0;
      r_result   <= '0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_acc      <= w_acc_nxt;
      r_ovf_run  <= w_ovf_run_nxt;
      r_result   <= w_result_nxt;
      r_overflow <= w_overflow_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_acc_nxt      = r_acc;
    w_ovf_run_nxt  = r_ovf_run;
    w_result_nxt   = r_result;
    w_overflow_nxt = r_overflow;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_load         = 1'b0;
    w_dec          = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load        = 1'b1;
          w_acc_nxt     = SIZE'(ACC_INIT);
          w_ovf_run_nxt = 1'b0;
          w_busy_nxt    = 1'b1;
          w_state_nxt   = RUN;
        end
      end
      RUN: begin
        if (w_gt) begin
          w_dec         = 1'b1;
          w_acc_nxt     = w_prod[SIZE-1:0];
          w_ovf_run_nxt = r_ovf_run | w_prod_ovf;
        end else begin
          w_result_nxt   = r_acc;
          w_overflow_nxt = r_ovf_run;
          w_done_nxt     = 1'b1;
          w_busy_nxt     = 1'b0;
          w_state_nxt    = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_fact_iter_unit.sv
// Self-checking bench for fact_iter_unit: vector table plus scoreboard of completions.
module tb_fact_iter_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] n = 8'd0;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       overflow;

  fact_iter_unit #(.SIZE(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .n        (n),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] res;
    logic       ovf;
    int         acc_cyc;
    int         done_cyc;
  } exp_t;

  typedef struct {
    logic [7:0] n;
    logic [7:0] res;
    logic       ovf;
  } vec_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         mon_en = 1'b0;
  logic [7:0] hold_res = 8'd0;
  logic       hold_ovf = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  function automatic void fact_model(input logic [7:0] nv, output logic [7:0] r, output logic o);
    logic [15:0] p;
    r = 8'd1;
    o = 1'b0;
    for (int k = int'(nv); k >= 2; k--) begin
      p = 16'(r) * 16'(k);
      if (p > 16'd255) o = 1'b1;
      r = p[7:0];
    end
  endfunction

  // Checks busy/done every cycle, completions against the scoreboard, holds otherwise.
  always @(negedge clk) begin
    if (mon_en) begin
      logic eb;
      logic ed;
      exp_t e;
      eb = 1'b0;
      ed = 1'b0;
      if (sb.size() > 0) begin
        if (cyc >= sb[0].acc_cyc && cyc < sb[0].done_cyc) eb = 1'b1;
        if (cyc == sb[0].done_cyc) ed = 1'b1;
      end
      chk("busy", int'(busy), int'(eb));
      chk("done", int'(done), int'(ed));
      if (done && sb.size() > 0) begin
        e = sb.pop_front();
        chk("result", int'(result), int'(e.res));
        chk("overflow", int'(overflow), int'(e.ovf));
        hold_res = e.res;
        hold_ovf = e.ovf;
      end else if (!done) begin
        chk("result_hold", int'(result), int'(hold_res));
        chk("overflow_hold", int'(overflow), int'(hold_ovf));
      end
    end
  end

  // Called at a negedge: raise start and book the expected completion.
  task automatic issue(input logic [7:0] nv, input logic [7:0] er, input logic eo);
    exp_t e;
    int   lat;
    lat = (nv > 8'd1) ? int'(nv) : 1;
    start = 1'b1;
    n = nv;
    e.res = er;
    e.ovf = eo;
    e.acc_cyc = cyc + 1;
    e.done_cyc = cyc + 1 + lat;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 600; i++) begin
      if (sb.size() == 0) return;
      @(negedge clk);
    end
    n_cmp++;
    n_bad++;
    $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    sb.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    hold_res = 8'd0;
    hold_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_one(input logic [7:0] nv, input logic [7:0] er, input logic eo);
    @(negedge clk);
    issue(nv, er, eo);
    @(negedge clk);
    start = 1'b0;
    drain();
  endtask

  vec_t       vecs[8];
  logic [7:0] mr;
  logic       mo;
  logic [7:0] rn;
  bit         seen;

  initial begin
    vecs[0] = '{n: 8'd5, res: 8'd120, ovf: 1'b0};
    vecs[1] = '{n: 8'd6, res: 8'd208, ovf: 1'b1};
    vecs[2] = '{n: 8'd4, res: 8'd24,  ovf: 1'b0};
    vecs[3] = '{n: 8'd0, res: 8'd1,   ovf: 1'b0};
    vecs[4] = '{n: 8'd1, res: 8'd1,   ovf: 1'b0};
    vecs[5] = '{n: 8'd3, res: 8'd6,   ovf: 1'b0};
    vecs[6] = '{n: 8'd8, res: 8'd128, ovf: 1'b1};
    vecs[7] = '{n: 8'd2, res: 8'd2,   ovf: 1'b0};

    do_reset();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_overflow", int'(overflow), 0);
    mon_en = 1'b1;

    for (int i = 0; i < 8; i++) run_one(vecs[i].n, vecs[i].res, vecs[i].ovf);

    for (int i = 0; i < 4; i++) begin
      rn = 8'($urandom_range(0, 12));
      fact_model(rn, mr, mo);
      run_one(rn, mr, mo);
    end

    // Start while busy is ignored; start in the done cycle is accepted.
    @(negedge clk);
    issue(8'd5, 8'd120, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    n = 8'd3;
    @(negedge clk);
    start = 1'b0;
    n = 8'd0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        issue(8'd3, 8'd6, 1'b0);
      end
    end
    chk("b2b_done_seen", int'(seen), 1);
    @(negedge clk);
    start = 1'b0;
    drain();

    // Reset mid-computation aborts with no completion.
    @(negedge clk);
    issue(8'd7, 8'd176, 1'b1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    do_reset();
    chk("abort_busy", int'(busy), 0);
    chk("abort_result", int'(result), 0);
    chk("abort_overflow", int'(overflow), 0);
    repeat (10) @(negedge clk);
    run_one(8'd2, 8'd2, 1'b0);

    run_one(8'd255, 8'd0, 1'b1);
    repeat (10) @(negedge clk);
    chk("idle_hold_result", int'(result), 0);
    chk("idle_hold_overflow", int'(overflow), 1);
    chk("idle_busy", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fact_iter_unit.md
Name: fact_iter_unit

Overview:
- Iterative unsigned factorial engine: result = n! truncated to SIZE bits.
- Bundles a loadable down-counter, a truncating SIZE x SIZE multiplier and an unsigned greater-than-one comparator, sequenced by a two-state controller.
- Sits below the top-level factorial controller, which pulses start and consumes result on done.

Parameters:
- SIZE, 8, width of n, the counter, the accumulator and result.

Ports:
- clk  input  1  single rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request computation of n!, sampled only while idle
- n  input  SIZE  unsigned operand, sampled on the accepting edge
- busy  output  1  high while a computation is in progress
- done  output  1  one-cycle pulse: result just updated
- result  output  SIZE  last completed n! modulo 2^SIZE, held until the next completion
- overflow  output  1  last completed computation lost high product bits

Interface:
- One clock; reset is synchronous and active-high.
- Clock port is clk; reset port is rst.

Behaviour:
- Reset (rst high at a rising edge):
  - state <= IDLE; cnt, acc and result <= 0.
  - busy, done, overflow <= 0.
  - rst has priority over every other input.
- IDLE:
  - On start=1: cnt <= n, acc <= 1, ovf_run <= 0, state <= RUN, busy <= 1.
  - Otherwise all registers hold.
- RUN, comparator gt = (cnt > 1) unsigned:
  - gt=1: acc <= (acc*cnt)[SIZE-1:0]; cnt <= cnt-1.
  - gt=1 also: ovf_run <= ovf_run | (full 2*SIZE product exceeds 2^SIZE-1).
  - gt=0: result <= acc, overflow <= ovf_run, done <= 1, busy <= 0, state <= IDLE.
- done is high for exactly one cycle (the cycle following the completion edge), otherwise 0.
- Latency: done and the new result appear max(n,1) rising edges after the edge that accepts start.
  - n=0 and n=1 both give result 1 after 1 edge.
  - The counter never decrements below 1, so there is no wrap-around.
- start while busy is ignored; the in-flight computation is unaffected and n is not resampled.
- start high in the done cycle (state already IDLE) is accepted: back-to-back computations are legal.
- result and overflow change only at completion or reset; they are stable while busy.
- rst mid-computation aborts with no done pulse; outputs go to their reset values.
- Arithmetic:
  - All unsigned.
  - Multiplier is purely combinational, with its output truncated to SIZE bits.
  - Overflow is detected from the untruncated product.

Decomposition:
- Shared package fact_pkg:
  - state enum {IDLE, RUN}.
  - Localparams for the accumulator init value 1 and the compare threshold 1.
- One natural sub-module: fact_down_cnt, a SIZE-bit counter.
  - Synchronous load of d, decrement on en, clear on rst.
- Comparator and multiplier stay inline as continuous assigns.

Test Plan:
- SIZE=8, rst, then start with n=5 -> done pulses exactly 5 cycles after acceptance, result=120, overflow=0, busy high for those 5 cycles.
- n=6 -> result=208 (720 mod 256), overflow=1. Then n=4 -> result=24, overflow cleared to 0.
- n=0, then n=1 -> each gives result=1 with done 1 cycle after acceptance and overflow=0.
- Start n=5; pulse start with n=3 two cycles later -> second request ignored, result=120 at the original latency. Start asserted in the done cycle with n=3 -> accepted, result=6 three cycles later.
- Start n=7; assert rst at cycle 3 -> no done pulse; result=0, busy=0, overflow=0. The next start with n=2 yields result=2.
- n=255 -> done after 255 cycles, result=0, overflow=1. result holds stable for 10 idle cycles afterwards.
